overture_fetch: RTL and testbench

- Instruction fetch/decode stage that sits directly upstream of the combinational program ROM and downstream of nothing but reset.
- Owns the program counter, drives the ROM address, and registers the returned byte into an instruction register.
- Decodes the byte into the 2-bit-class Overture format and hands it to the execute stage over a valid/ready handshake.
- Accepts branch redirects from execute.

---
 rtl/overture_fetch_if.sv | 26 ++
 rtl/overture_fetch.sv | 84 ++++++++
 tb/tb_overture_fetch.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/overture_fetch_if.sv
// Fetch-side bundle: program ROM port, decoded-instruction handshake to execute, and the branch redirect.
interface overture_fetch_if #(parameter int ADDR_W = 8);
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              insn_valid;
  logic              insn_ready;
  logic [7:0]        insn;
  logic [ADDR_W-1:0] insn_pc;
  logic              is_imm, is_calc, is_copy, is_cond;
  logic [5:0]        imm6;
  logic [2:0]        src, dst, func;
  logic              br_valid;
  logic [ADDR_W-1:0] br_target;

  modport master (
    output rom_addr, insn_valid, insn, insn_pc,
           is_imm, is_calc, is_copy, is_cond, imm6, src, dst, func,
    input  rom_data, insn_ready, br_valid, br_target
  );

  modport slave (
    input  rom_addr, insn_valid, insn, insn_pc,
           is_imm, is_calc, is_copy, is_cond, imm6, src, dst, func,
    output rom_data, insn_ready, br_valid, br_target
  );
endinterface

// File: rtl/overture_fetch.sv
// Overture fetch/decode: owns the PC, registers the ROM byte, decodes it, hands it off over valid/ready.
// Define OVERTURE_FETCH_PERF_EN to add saturating transfer/stall counters.
module overture_fetch #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  overture_fetch_if.master  bus
`ifdef OVERTURE_FETCH_PERF_EN
  ,
  output logic [15:0]       perf_fetch_cnt,
  output logic [15:0]       perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc, insn_pc;
  logic [7:0]        insn;
  logic              insn_valid;
  logic              adv;

  assign adv = (state != IDLE) && (!insn_valid || bus.insn_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      insn       <= 8'h00;
      insn_pc    <= '0;
      insn_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= RUN;  // bubble cycle: no fetch, redirects ignored
        default: begin
          if (bus.br_valid) begin
            // redirect flushes the held instruction regardless of ready
            pc         <= bus.br_target;
            insn_valid <= 1'b0;
            state      <= RUN;
          end else begin
            if (adv) begin
              insn       <= bus.rom_data;
              insn_pc    <= pc;
              insn_valid <= 1'b1;
              pc         <= pc + 1'b1;
            end
            state <= (insn_valid && !bus.insn_ready) ? STALL : RUN;
          end
        end
      endcase
    end
  end

  assign bus.rom_addr   = pc;
  assign bus.insn_valid = insn_valid;
  assign bus.insn       = insn;
  assign bus.insn_pc    = insn_pc;
  assign bus.is_imm     = (insn[7:6] == 2'b00);
  assign bus.is_calc    = (insn[7:6] == 2'b01);
  assign bus.is_copy    = (insn[7:6] == 2'b10);
  assign bus.is_cond    = (insn[7:6] == 2'b11);
  assign bus.imm6       = insn[5:0];
  assign bus.src        = insn[5:3];
  assign bus.dst        = insn[2:0];
  assign bus.func       = insn[2:0];

`ifdef OVERTURE_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= 16'h0000;
      perf_stall_cnt <= 16'h0000;
    end else begin
      if (insn_valid && bus.insn_ready && perf_fetch_cnt != 16'hFFFF)
        perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
      if (insn_valid && !bus.insn_ready && perf_stall_cnt != 16'hFFFF)
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_overture_fetch.sv
// Bench for overture_fetch: directed vector table, async-reset check, then random traffic against a reference model.
module tb_overture_fetch;

  logic clk, rst_n;
  logic [7:0] rom [256];
  int vectors = 0;
  int errors  = 0;

  overture_fetch_if #(.ADDR_W(8)) bus();

  assign bus.rom_data = rom[bus.rom_addr];

`ifdef OVERTURE_FETCH_PERF_EN
  logic [15:0] pf, ps;
  overture_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .perf_fetch_cnt(pf), .perf_stall_cnt(ps));
`else
  overture_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: state of the fetch stage as the spec describes it
  logic       m_run, m_valid;
  logic [7:0] m_pc, m_insn, m_ipc;
  int         m_fc, m_sc;

  task automatic model_reset();
    m_run = 1'b0; m_valid = 1'b0; m_pc = 8'h00; m_insn = 8'h00; m_ipc = 8'h00;
    m_fc = 0; m_sc = 0;
  endtask

  task automatic tick(input logic rdy, input logic br, input logic [7:0] tgt);
    bus.insn_ready = rdy; bus.br_valid = br; bus.br_target = tgt;
    @(posedge clk);
    if (m_valid && rdy && m_fc < 65535) m_fc++;
    if (m_valid && !rdy && m_sc < 65535) m_sc++;
    if (!m_run) m_run = 1'b1;
    else if (br) begin m_pc = tgt; m_valid = 1'b0; end
    else if (!m_valid || rdy) begin
      m_insn = rom[m_pc]; m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 8'd1;
    end
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic ev, input logic [7:0] ei,
                       input logic [7:0] eipc, input logic [7:0] epc);
    logic [1:0]  cls;
    logic [3:0]  ecls, gcls;
    logic [14:0] edec, gdec;
    cls  = ei[7:6];
    ecls = 4'b0001 << cls;
    gcls = {bus.is_cond, bus.is_copy, bus.is_calc, bus.is_imm};
    edec = {ei[5:0], ei[5:3], ei[2:0], ei[2:0]};
    gdec = {bus.imm6, bus.src, bus.dst, bus.func};
    vectors++;
    if (bus.insn_valid !== ev || bus.insn !== ei || bus.insn_pc !== eipc ||
        bus.rom_addr !== epc || gcls !== ecls || gdec !== edec) begin
      errors++;
      $display("FAIL %s: got v=%0b insn=%02h ipc=%02h pc=%02h cls=%b dec=%h, required v=%0b insn=%02h ipc=%02h pc=%02h cls=%b dec=%h",
               nm, bus.insn_valid, bus.insn, bus.insn_pc, bus.rom_addr, gcls, gdec,
               ev, ei, eipc, epc, ecls, edec);
    end
  endtask

  typedef struct {
    logic       rdy, br;
    logic [7:0] tgt;
    logic       ev;
    logic [7:0] ei, eipc, epc;
  } vec_t;

  function automatic vec_t mk(logic rdy, logic br, logic [7:0] tgt,
                              logic ev, logic [7:0] ei, logic [7:0] eipc, logic [7:0] epc);
    vec_t v;
    v.rdy = rdy; v.br = br; v.tgt = tgt; v.ev = ev; v.ei = ei; v.eipc = eipc; v.epc = epc;
    return v;
  endfunction

  vec_t tbl [18];

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[8'h00] = 8'h02; rom[8'h01] = 8'h86; rom[8'h05] = 8'h86;
    rom[8'h0D] = 8'hB3; rom[8'h0E] = 8'h14; rom[8'h20] = 8'hC1; rom[8'hFF] = 8'h4A;

    //            rdy   br    tgt    v     insn   ipc    pc
    tbl[0]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);  // idle bubble
    tbl[1]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 8'h00, 8'h01);
    tbl[2]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h86, 8'h01, 8'h02);
    tbl[3]  = mk(1'b1, 1'b1, 8'h0D, 1'b0, 8'h86, 8'h01, 8'h0D);
    tbl[4]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'hB3, 8'h0D, 8'h0E);
    tbl[5]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 8'hB3, 8'h0D, 8'h0E);  // stall x3
    tbl[6]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 8'hB3, 8'h0D, 8'h0E);
    tbl[7]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 8'hB3, 8'h0D, 8'h0E);
    tbl[8]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h14, 8'h0E, 8'h0F);
    tbl[9]  = mk(1'b0, 1'b1, 8'h05, 1'b0, 8'h14, 8'h0E, 8'h05);  // flush while not ready
    tbl[10] = mk(1'b0, 1'b0, 8'h00, 1'b1, 8'h86, 8'h05, 8'h06);
    tbl[11] = mk(1'b0, 1'b0, 8'h00, 1'b1, 8'h86, 8'h05, 8'h06);
    tbl[12] = mk(1'b1, 1'b1, 8'hFF, 1'b0, 8'h86, 8'h05, 8'hFF);
    tbl[13] = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h4A, 8'hFF, 8'h00);  // wrap
    tbl[14] = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 8'h00, 8'h01);
    tbl[15] = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h86, 8'h01, 8'h02);
    tbl[16] = mk(1'b1, 1'b1, 8'h20, 1'b0, 8'h86, 8'h01, 8'h20);
    tbl[17] = mk(1'b0, 1'b0, 8'h00, 1'b1, 8'hC1, 8'h20, 8'h21);  // COND decode

    rst_n = 1'b0;
    bus.insn_ready = 1'b0; bus.br_valid = 1'b0; bus.br_target = 8'h00;
    model_reset();
    #12;
    check("reset", 1'b0, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      tick(tbl[i].rdy, tbl[i].br, tbl[i].tgt);
      check($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ei, tbl[i].eipc, tbl[i].epc);
    end

    // reset mid-stream takes effect without a clock edge
    #2 rst_n = 1'b0;
    #1 check("async_reset", 1'b0, 8'h00, 8'h00, 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // redirect during the idle bubble is ignored
    tick(1'b1, 1'b1, 8'h77);
    check("idle_br", m_valid, m_insn, m_ipc, m_pc);

    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0), 8'($urandom));
      check("rand", m_valid, m_insn, m_ipc, m_pc);
`ifdef OVERTURE_FETCH_PERF_EN
      vectors++;
      if (pf !== 16'(m_fc) || ps !== 16'(m_sc)) begin
        errors++;
        $display("FAIL rand_perf: got fetch=%0d stall=%0d, required fetch=%0d stall=%0d", pf, ps, m_fc, m_sc);
      end
`endif
    end

`ifdef OVERTURE_FETCH_PERF_EN
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 8'h00);
    vectors++;
    if (pf !== 16'd10 || ps !== 16'd4) begin
      errors++;
      $display("FAIL perf_counts: got fetch=%0d stall=%0d, required fetch=10 stall=4", pf, ps);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
